// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store data memory: funct3 size encodings,
// lane geometry and the lane-mask helper used by the store path.
package lsu_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        FnByte  = 3'b000,
        FnHalf  = 3'b001,
        FnWord  = 3'b010,
        FnByteU = 3'b100,
        FnHalfU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        SzByte,
        SzHalf,
        SzWord,
        SzNone
    } size_e;

    function automatic size_e decode_size(input logic [2:0] f3);
        case (f3)
            FnByte, FnByteU: return SzByte;
            FnHalf, FnHalfU: return SzHalf;
            FnWord:          return SzWord;
            default:         return SzNone;
        endcase
    endfunction

    // Lanes touched by an access; misaligned cases are rejected before use.
    function automatic logic [LANES-1:0] lane_mask(input size_e sz, input logic [1:0] lane);
        case (sz)
            SzByte:  return 4'b0001 << lane;
            SzHalf:  return 4'b0011 << lane;
            SzWord:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load alignment: selects the addressed byte/half lane of a memory word and
// sign- or zero-extends it to 32 bits according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        lane,
    input  logic [2:0]        funct3,
    output logic [WORD_W-1:0] data
);

    logic [WORD_W-1:0] shifted;

    always_comb begin
        shifted = word >> {lane, 3'b000};
        case (funct3)
            FnByte:  data = {{(WORD_W - BYTE_W){shifted[BYTE_W-1]}}, shifted[BYTE_W-1:0]};
            FnHalf:  data = {{(WORD_W - HALF_W){shifted[HALF_W-1]}}, shifted[HALF_W-1:0]};
            FnByteU: data = {{(WORD_W - BYTE_W){1'b0}}, shifted[BYTE_W-1:0]};
            FnHalfU: data = {{(WORD_W - HALF_W){1'b0}}, shifted[HALF_W-1:0]};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/lsu_data_memory.sv
// Byte-addressed data memory with per-lane stores, extended loads, fault
// detection and a single registered response stage (rvalid/err/readdata).
module lsu_data_memory
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH        = 128,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned INIT_PATTERN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] address,
    input  logic [WORD_W-1:0] writedata,
    output logic [WORD_W-1:0] readdata,
    output logic              rvalid,
    output logic              err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    size_e             size;
    logic [IDX_W-1:0]  word_idx;
    logic [1:0]        lane;
    logic              req;
    logic              misaligned;
    logic              out_of_range;
    logic              fault;
    logic              do_write;
    logic [LANES-1:0]  lane_we;
    logic [WORD_W-1:0] wdata_rep;
    logic [WORD_W-1:0] rd_word;
    logic [WORD_W-1:0] load_data;
    logic [WORD_W-1:0] mem [DEPTH];

    logic [WORD_W-1:0] readdata_q;
    logic              rvalid_q;
    logic              err_q;

    assign word_idx = address[IDX_W+1:2];
    assign lane     = address[1:0];
    assign size     = decode_size(funct3);

    always_comb begin
        req          = memread | memwrite;
        misaligned   = (size == SzHalf && lane[0]) || (size == SzWord && lane != 2'b00);
        out_of_range = (address >> (IDX_W + 2)) != '0;
        fault        = (size == SzNone) | misaligned | out_of_range | (memread & memwrite);
        do_write     = rst_n & memwrite & ~fault;
        lane_we      = do_write ? lane_mask(size, lane) : '0;
        // Replicate store data so every candidate lane sees its bytes.
        case (size)
            SzByte:  wdata_rep = {4{writedata[BYTE_W-1:0]}};
            SzHalf:  wdata_rep = {2{writedata[HALF_W-1:0]}};
            default: wdata_rep = writedata;
        endcase
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [WORD_W-1:0] word_q = (INIT_PATTERN != 0) ? WORD_W'(i * 10) : '0;

        always_ff @(posedge clk) begin
            for (int b = 0; b < int'(LANES); b++) begin
                if (lane_we[b] && word_idx == IDX_W'(i)) begin
                    word_q[b*BYTE_W +: BYTE_W] <= wdata_rep[b*BYTE_W +: BYTE_W];
                end
            end
        end

        assign mem[i] = word_q;
    end

    assign rd_word = mem[word_idx];

    lsu_load_align u_load_align (
        .word   (rd_word),
        .lane   (lane),
        .funct3 (funct3),
        .data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            readdata_q <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rvalid_q <= req;
            err_q    <= req & fault;
            if (req && fault) begin
                readdata_q <= '0;
            end else if (memread) begin
                readdata_q <= load_data;
            end
        end
    end

    // A response still in flight when reset arrives is never presented.
    assign readdata = readdata_q;
    assign rvalid   = rvalid_q & rst_n;
    assign err      = err_q & rst_n;

endmodule

// File: tb/tb_lsu_data_memory.sv
// Scoreboard bench for lsu_data_memory: stimulus pushes expected responses
// from a byte-array reference model; a negedge monitor pops and compares.
module tb_lsu_data_memory;

    localparam int DEPTH = 128;

    typedef struct {
        bit          is_load;
        bit          err;
        logic [31:0] data;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memread = 1'b0;
    logic        memwrite = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        rvalid;
    logic        err;

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [7:0] ref_mem [4*DEPTH];

    lsu_data_memory #(
        .DEPTH        (DEPTH),
        .ADDR_W       (32),
        .INIT_PATTERN (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .memread   (memread),
        .memwrite  (memwrite),
        .funct3    (funct3),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata),
        .rvalid    (rvalid),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    // Reference: byte-addressed little-endian array; faults from the access rules.
    function automatic void model(input bit rd, input bit wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input string tag, output exp_t e);
        int unsigned size;
        bit          bad;
        logic [31:0] v;
        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        size = 0;
        endcase
        bad = (rd && wr) || size == 0 || a >= 32'(4 * DEPTH);
        if (size != 0 && (a % size) != 0) bad = 1'b1;
        e.is_load = rd && !wr;
        e.err     = bad;
        e.data    = '0;
        e.tag     = tag;
        if (!bad && wr) begin
            for (int k = 0; k < int'(size); k++) ref_mem[a + k] = wd[8*k +: 8];
        end
        if (!bad && rd) begin
            v = '0;
            for (int k = 0; k < int'(size); k++) v[8*k +: 8] = ref_mem[a + k];
            if (f3 == 3'b000 && v[7])  v = v - 32'h100;
            if (f3 == 3'b001 && v[15]) v = v - 32'h10000;
            e.data = v;
        end
    endfunction

    task automatic issue(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input string tag);
        exp_t e;
        #1;
        memread = rd; memwrite = wr; funct3 = f3; address = a; writedata = wd;
        @(posedge clk);
        if (rst_n && (rd || wr)) begin
            model(rd, wr, f3, a, wd, tag, e);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        #1;
        memread = 1'b0; memwrite = 1'b0;
        @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (rvalid) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_rvalid: got rvalid=1, expected no response");
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.tag, "_err"}, {31'b0, err}, {31'b0, mon_e.err});
                if (mon_e.is_load) check({mon_e.tag, "_data"}, readdata, mon_e.data);
            end
        end else begin
            check("err_without_rvalid", {31'b0, err}, 32'd0);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                n_cmp++; n_fail++;
                $display("FAIL %s_missing: got rvalid=0, expected rvalid=1", mon_e.tag);
            end
        end
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        int          op;
        logic [2:0]  legal_f3 [5];
        legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
        legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;

        for (int w = 0; w < DEPTH; w++) begin
            for (int k = 0; k < 4; k++) ref_mem[4*w + k] = 8'((w * 10) >> (8 * k));
        end

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("reset_readdata", readdata, 32'd0);
        check("reset_rvalid", {31'b0, rvalid}, 32'd0);
        check("reset_err", {31'b0, err}, 32'd0);

        issue(1, 0, 3'b010, 32'h08, '0, "lw_08");
        issue(0, 1, 3'b000, 32'h05, 32'h0000_00F0, "sb_05");
        issue(1, 0, 3'b000, 32'h05, '0, "lb_05");
        issue(1, 0, 3'b100, 32'h05, '0, "lbu_05");
        issue(1, 0, 3'b010, 32'h04, '0, "lw_04");
        issue(1, 0, 3'b001, 32'h03, '0, "lh_03_misaligned");
        issue(0, 1, 3'b010, 32'h06, 32'h1111_2222, "sw_06_misaligned");
        issue(1, 0, 3'b010, 32'h04, '0, "lw_04_after_bad_sw");
        issue(1, 1, 3'b010, 32'h20, 32'h1234_5678, "rd_wr_conflict");
        issue(1, 0, 3'b010, 32'h20, '0, "lw_20_after_conflict");
        issue(1, 0, 3'b010, 32'h200, '0, "lw_200_oob");
        issue(1, 0, 3'b011, 32'h00, '0, "illegal_f3");
        issue(0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF, "sw_10");
        issue(1, 0, 3'b010, 32'h10, '0, "lw_10_raw");
        issue(0, 1, 3'b001, 32'h1E, 32'h0000_8001, "sh_1e");
        issue(1, 0, 3'b001, 32'h1E, '0, "lh_1e");
        issue(1, 0, 3'b101, 32'h1E, '0, "lhu_1e");
        for (int i = 0; i < 8; i++) issue(1, 0, 3'b010, 32'(4 * i), '0, "burst_lw");
        idle();

        // Reset the cycle after a load: its response must never appear.
        issue(1, 0, 3'b010, 32'h0C, '0, "lw_before_reset");
        #1;
        rst_n = 1'b0; memread = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        issue(0, 1, 3'b010, 32'h0C, 32'hCAFE_F00D, "sw_in_reset");
        #1 rst_n = 1'b1;
        idle();
        issue(1, 0, 3'b010, 32'h0C, '0, "lw_0c_after_reset");

        for (int n = 0; n < 400; n++) begin
            op = int'($urandom_range(0, 19));
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
            a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH-1));
            if (op < 8)       issue(1, 0, f3, a, '0, "rand_load");
            else if (op < 16) issue(0, 1, f3, a, $urandom, "rand_store");
            else if (op < 18) idle();
            else              issue(1, 1, f3, a, $urandom, "rand_conflict");
        end

        idle();
        idle();
        idle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
